// File: rtl/alu_mul_seq_if.sv
// Multiplier-side bundle: start/busy/done handshake plus the ALU operand/result bus.
// With MUL_OVF_EN defined the bundle also carries the ovf result flag.
interface alu_mul_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_y;
  logic [5:0]       alu_signal;
  logic [WIDTH-1:0] alu_out;
  logic             alu_cout;
`ifdef MUL_OVF_EN
  logic             ovf;

  modport master (
    output start, a, b, alu_out, alu_cout,
    input  busy, done, product, alu_x, alu_y, alu_signal, ovf
  );
  modport slave (
    input  start, a, b, alu_out, alu_cout,
    output busy, done, product, alu_x, alu_y, alu_signal, ovf
  );
`else
  modport master (
    output start, a, b, alu_out, alu_cout,
    input  busy, done, product, alu_x, alu_y, alu_signal
  );
  modport slave (
    input  start, a, b, alu_out, alu_cout,
    output busy, done, product, alu_x, alu_y, alu_signal
  );
`endif
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the Hack ALU's x+y as its only adder.
// Optional sticky overflow flag and ovf output enabled by defining MUL_OVF_EN.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_mul_seq_if.slave  bus
);

  localparam logic [5:0] ALU_ZERO = 6'b101010;
  localparam logic [5:0] ALU_ADD  = 6'b000010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] product_q, product_d;
  logic [5:0]       alu_sig;
`ifdef MUL_OVF_EN
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;
`else
  logic             unused_alu_cout;
  assign unused_alu_cout = bus.alu_cout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      product_q <= '0;
`ifdef MUL_OVF_EN
      flag_q    <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      product_q <= product_d;
`ifdef MUL_OVF_EN
      flag_q    <= flag_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    product_d = product_q;
    alu_sig   = ALU_ZERO;
`ifdef MUL_OVF_EN
    flag_d    = flag_q;
    ovf_d     = ovf_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
`ifdef MUL_OVF_EN
          flag_d   = 1'b0;
`endif
          state_d  = (bus.b == '0) ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        alu_sig  = ALU_ADD;
        if (mplier_q[0]) acc_d = bus.alu_out;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
`ifdef MUL_OVF_EN
        // A carry from a real add, or a set bit about to be shifted out while
        // higher multiplier bits still need it, both mean the product wrapped.
        if ((mplier_q[0] && bus.alu_cout) ||
            (mcand_q[WIDTH-1] && (mplier_d != '0))) begin
          flag_d = 1'b1;
        end
`endif
        if (mplier_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result is captured on the edge entering DONE so it is valid alongside done.
    if (state_d == S_DONE) begin
      product_d = acc_d;
`ifdef MUL_OVF_EN
      ovf_d     = flag_d;
`endif
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.product    = product_q;
  assign bus.alu_x      = acc_q;
  assign bus.alu_y      = mcand_q;
  assign bus.alu_signal = alu_sig;
`ifdef MUL_OVF_EN
  assign bus.ovf        = ovf_q;
`endif

endmodule
